seq_mul: RTL

//  Iterative shift-add multiplier, the parametrised sequential successor to the

---
 rtl/seq_mul.sv | 106 ++++++++++
 1 files changed

// File: rtl/seq_mul.sv
// Iterative shift-add multiplier: one partial product per clock, full 2*WIDTH-bit
// product, unsigned or two's-complement selected per operation.
module seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic            sgn_q;
  logic [CW-1:0]   count;
  logic [PW-1:0]   acc;

  logic [PW-1:0]   m;
  logic [PW-1:0]   addend;
  logic [PW-1:0]   acc_next;
  logic            last;

  // The multiplier's MSB carries weight -2^(WIDTH-1) in signed mode, hence the subtract.
  always_comb begin
    m        = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    addend   = m << count;
    last     = (count == CW'(WIDTH - 1));
    acc_next = acc;
    if (b_q[count]) begin
      if (sgn_q && last) acc_next = acc - addend;
      else               acc_next = acc + addend;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      count     <= '0;
      acc       <= '0;
      product   <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= op1;
            b_q      <= op2;
            sgn_q    <= is_signed;
            acc      <= '0;
            count    <= '0;
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          acc <= acc_next;
          if (last) begin
            product   <= acc_next;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            count <= count + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
